sd_spi_responder: RTL and testbench
===================================

SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 SHALL have parameter ACMD41_BUSY, default 2, number of ACMD41 replies of 0x01 before 0x00.
REQ-002 SHALL have parameter BUSY_BYTES, default 2, number of 0x00 busy bytes after a write data-response.
REQ-003 SHALL have parameter OCR, default 32'h80FF8000, OCR value returned by CMD58.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk in 1, system clock; rst_l in 1, async active-low reset.
REQ-005 SHALL have ports sck in 1, SPI clock; mosi in 1, master data; cs_l in 1, active-low chip select.
REQ-006 SHALL have ports miso out 1, responder data; miso_oe out 1, high while cs_l is low.
REQ-007 SHALL have ports mem_addr out 16, {block[6:0], byte[8:0]}; mem_rdata in 8, read data one clk after mem_addr.
REQ-008 SHALL have ports mem_we out 1, one-clk write strobe; mem_wdata out 8, write byte; card_ready out 1, initialization complete.

Function
REQ-009 SHALL pass sck, mosi and cs_l through 2-flop synchronizers; supported sck frequency is at most clk/8.
REQ-010 SHALL use SPI mode 0: sample mosi on the synchronized sck rising edge and update miso on the falling edge, MSB first.
REQ-011 SHALL start a 48-bit command frame at the first '01' bit pair while in S_CMD; frames with end bit 0 are ignored; CRC7 is not checked.
REQ-012 SHALL have states S_CMD, S_NCR, S_RESP, S_RDTOK, S_RDDATA, S_RDCRC, S_WRTOK, S_WRDATA, S_WRCRC, S_WRRESP, S_BUSY.
REQ-013 SHALL output one 0xFF byte (S_NCR) after each command frame, then the response bytes (S_RESP); miso SHALL be 1 whenever no byte is defined.
REQ-014 SHALL on CMD0 reply R1 0x01 and set idle=1, app=0, ACMD41 counter=0, card_ready=0.
REQ-015 SHALL on CMD8 reply R7: {idle}, 0x00, 0x00, {4'h0, arg[11:8]}, arg[7:0].
REQ-016 SHALL on CMD55 reply R1 {7'b0, idle} and set app=1; app SHALL clear after the next command of any kind.
REQ-017 SHALL on ACMD41 (app=1) reply 0x01 and increment the counter while counter < ACMD41_BUSY, else reply 0x00 and set idle=0, card_ready=1.
REQ-018 SHALL on CMD58 reply R3: {7'b0, idle}, then OCR MSB first.
REQ-019 SHALL reply R1 {5'b0, 1'b1, 1'b0, idle} (illegal command) for any other index, and for CMD17/CMD24 while idle=1.
REQ-020 SHALL on CMD17 with idle=0: reply R1 0x00, one 0xFF, token 0xFE, 512 bytes of mem_rdata at mem_addr {arg[15:9], 0..511}, then 0xFF, 0xFF.
REQ-021 SHALL present mem_addr for byte n at least one clk before byte n is loaded into the miso shifter.
REQ-022 SHALL on CMD24 with idle=0: reply R1 0x00, then enter S_WRTOK and skip 0xFF bytes until 0xFE is received.
REQ-023 SHALL in S_WRTOK treat any byte other than 0xFF or 0xFE as an abort and return to S_CMD.
REQ-024 SHALL in S_WRDATA pulse mem_we for one clk per received byte, with mem_wdata = byte and mem_addr = {arg[15:9], n}, for n = 0..511.
REQ-025 SHALL ignore the 2 CRC bytes, then send data response 0x05, then BUSY_BYTES bytes of 0x00 (S_BUSY), then return to S_CMD.
REQ-026 SHALL wrap the 9-bit byte counter only at the transition 511 -> next state; mem_addr SHALL never cross a block boundary.
REQ-027 SHALL treat cs_l high as an abort at any time: return to S_CMD, clear the bit and byte counters, drive miso=1 and miso_oe=0, and suppress mem_we; idle, app and card_ready SHALL be retained.
REQ-028 SHALL ignore mosi while it is transmitting a response or read data.

Reset
REQ-029 SHALL on rst_l low asynchronously enter S_CMD with idle=1, app=0, ACMD41 counter=0, card_ready=0, miso=1, miso_oe=0, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-030 SHALL act on rst_l deassertion only at a clk edge, and SHALL ignore any SCK edges that were already in progress.

Verification
REQ-031 SHALL verify: reset, CMD0 48'h400000000095 -> 0xFF then 0x01.
REQ-032 SHALL verify: CMD8 48'h48000001AA87 -> 01 00 00 01 AA.
REQ-033 SHALL verify: CMD55 + ACMD41 repeated 3 times -> 0x01, 0x01, 0x00; card_ready=1; CMD58 -> 00 80 FF 80 00.
REQ-034 SHALL verify: CMD24 with arg 0x00000200, 0xFE, bytes 0..255 twice, CRC -> 512 mem_we pulses at addresses 0x0200..0x03FF, then 0x05, 00 00, FF.
REQ-035 SHALL verify: CMD17 with arg 0x00000200 -> 00, FF, FE, 512 bytes matching the memory model, FF FF.
REQ-036 SHALL verify: cs_l raised at byte 100 of CMD24 -> no further mem_we, miso_oe=0; the next CMD17 is answered normally; CMD17 before init -> 0x05.

Source files
------------

// File: rtl/sd_spi_responder.sv
// SD-card SPI-mode responder: init handshake (CMD0/8/55/ACMD41/58) plus single-block read (CMD17) and write (CMD24).
// Latency: one 0xFF byte after each command frame, then the response; read bytes are prefetched a full byte ahead.
// Backpressure: none; the SPI master paces every transfer, and cs_l high aborts to command hunting at any time.
`timescale 1ns/1ps
module sd_spi_responder #(
    parameter int unsigned ACMD41_BUSY = 2,
    parameter int unsigned BUSY_BYTES  = 2,
    parameter logic [31:0] OCR         = 32'h80FF8000
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        sck,
    input  logic        mosi,
    input  logic        cs_l,
    output logic        miso,
    output logic        miso_oe,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    output logic        card_ready
);

    typedef enum logic [3:0] {
        S_CMD, S_NCR, S_RESP, S_RDTOK, S_RDDATA, S_RDCRC,
        S_WRTOK, S_WRDATA, S_WRCRC, S_WRRESP, S_BUSY
    } state_t;

    localparam logic [7:0] ABUSY = 8'(ACMD41_BUSY);
    localparam logic [8:0] BLAST = 9'(BUSY_BYTES - 1);

    logic [1:0]  sck_sync_q, mosi_sync_q, cs_sync_q;
    logic        sck_prev_q;
    logic [1:0]  start_q;
    logic        sck_s, mosi_s, cs_s, sck_rise, sck_fall;

    state_t      state_q, after_q, after_d;
    logic [46:0] cmd_q;
    logic        frm_q;
    logic [5:0]  fcnt_q;
    logic [2:0]  bit_q;
    logic [6:0]  rx_q;
    logic [7:0]  tx_q, rx_byte;
    logic [8:0]  cnt_q;
    logic [6:0]  blk_q;
    logic [39:0] resp_q, resp_d;
    logic [2:0]  rcnt_q, rcnt_d;
    logic        idle_q, idle_d, app_q, app_d, ready_q, ready_d;
    logic [7:0]  acnt_q, acnt_d;
    logic        miso_q, miso_oe_q, mem_we_q;
    logic [15:0] mem_addr_q;
    logic [7:0]  mem_wdata_q;

    assign sck_s    = sck_sync_q[1];
    assign mosi_s   = mosi_sync_q[1];
    assign cs_s     = cs_sync_q[1];
    // Edges are only trusted once the synchronizer and history flop hold post-reset samples.
    assign sck_rise = (start_q == 2'd3) &&  sck_s && !sck_prev_q;
    assign sck_fall = (start_q == 2'd3) && !sck_s &&  sck_prev_q;
    assign rx_byte  = {rx_q, mosi_s};

    assign miso       = miso_q;
    assign miso_oe    = miso_oe_q;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign card_ready = ready_q;

    // Two-flop synchronizers for the SPI pins plus sck history for edge detection.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sck_sync_q  <= 2'b00;
            mosi_sync_q <= 2'b11;
            cs_sync_q   <= 2'b11;
            sck_prev_q  <= 1'b0;
            start_q     <= 2'd0;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], sck};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
            cs_sync_q   <= {cs_sync_q[0], cs_l};
            sck_prev_q  <= sck_s;
            if (start_q != 2'd3) start_q <= start_q + 2'd1;
        end
    end

    // Decode the completed frame held in cmd_q: frame bit k lives at cmd_q[k-1].
    always_comb begin
        idle_d  = idle_q;
        app_d   = 1'b0;
        acnt_d  = acnt_q;
        ready_d = ready_q;
        after_d = S_CMD;
        rcnt_d  = 3'd0;
        resp_d  = {5'b0, 1'b1, 1'b0, idle_q, 32'hFFFF_FFFF};
        case (cmd_q[44:39])
            6'd0: begin
                resp_d  = {8'h01, 32'hFFFF_FFFF};
                idle_d  = 1'b1;
                acnt_d  = 8'd0;
                ready_d = 1'b0;
            end
            6'd8: begin
                resp_d = {7'b0, idle_q, 8'h00, 8'h00, 4'h0, cmd_q[18:15], cmd_q[14:7]};
                rcnt_d = 3'd4;
            end
            6'd55: begin
                resp_d = {7'b0, idle_q, 32'hFFFF_FFFF};
                app_d  = 1'b1;
            end
            6'd41: begin
                if (app_q) begin
                    if (acnt_q < ABUSY) begin
                        resp_d = {8'h01, 32'hFFFF_FFFF};
                        acnt_d = acnt_q + 8'd1;
                    end else begin
                        resp_d  = {8'h00, 32'hFFFF_FFFF};
                        idle_d  = 1'b0;
                        ready_d = 1'b1;
                    end
                end
            end
            6'd58: begin
                resp_d = {7'b0, idle_q, OCR};
                rcnt_d = 3'd4;
            end
            6'd17: begin
                if (!idle_q) begin
                    resp_d  = {8'h00, 8'hFF, 24'hFF_FFFF};
                    rcnt_d  = 3'd1;
                    after_d = S_RDTOK;
                end
            end
            6'd24: begin
                if (!idle_q) begin
                    resp_d  = {8'h00, 32'hFFFF_FFFF};
                    after_d = S_WRTOK;
                end
            end
            default: ;
        endcase
    end

    // Protocol FSM: frame hunting, byte-level sequencing on sck rise, miso update on sck fall.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= S_CMD;
            after_q     <= S_CMD;
            cmd_q       <= '1;
            frm_q       <= 1'b0;
            fcnt_q      <= 6'd0;
            bit_q       <= 3'd0;
            rx_q        <= 7'd0;
            tx_q        <= 8'hFF;
            cnt_q       <= 9'd0;
            blk_q       <= 7'd0;
            resp_q      <= '1;
            rcnt_q      <= 3'd0;
            idle_q      <= 1'b1;
            app_q       <= 1'b0;
            acnt_q      <= 8'd0;
            ready_q     <= 1'b0;
            miso_q      <= 1'b1;
            miso_oe_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'd0;
            mem_wdata_q <= 8'd0;
        end else begin
            mem_we_q <= 1'b0;
            if (cs_s) begin
                state_q   <= S_CMD;
                cmd_q     <= '1;
                frm_q     <= 1'b0;
                fcnt_q    <= 6'd0;
                bit_q     <= 3'd0;
                cnt_q     <= 9'd0;
                tx_q      <= 8'hFF;
                miso_q    <= 1'b1;
                miso_oe_q <= 1'b0;
            end else begin
                miso_oe_q <= 1'b1;
                if (sck_fall) miso_q <= (state_q == S_CMD) ? 1'b1 : tx_q[~bit_q];
                if (sck_rise && state_q == S_CMD) begin
                    cmd_q <= {cmd_q[45:0], mosi_s};
                    if (!frm_q) begin
                        if (!cmd_q[0] && mosi_s) begin
                            frm_q  <= 1'b1;
                            fcnt_q <= 6'd2;
                        end
                    end else if (fcnt_q == 6'd47) begin
                        frm_q <= 1'b0;
                        cmd_q <= '1;
                        if (mosi_s) begin
                            idle_q  <= idle_d;
                            app_q   <= app_d;
                            acnt_q  <= acnt_d;
                            ready_q <= ready_d;
                            resp_q  <= resp_d;
                            rcnt_q  <= rcnt_d;
                            after_q <= after_d;
                            blk_q   <= cmd_q[22:16];
                            if (after_d == S_RDTOK) mem_addr_q <= {cmd_q[22:16], 9'd0};
                            state_q <= S_NCR;
                            tx_q    <= 8'hFF;
                            bit_q   <= 3'd0;
                        end
                    end else begin
                        fcnt_q <= fcnt_q + 6'd1;
                    end
                end else if (sck_rise) begin
                    bit_q <= bit_q + 3'd1;
                    rx_q  <= rx_byte[6:0];
                    if (bit_q == 3'd7) begin
                        tx_q <= 8'hFF;
                        case (state_q)
                            S_NCR, S_RESP: begin
                                if (state_q == S_RESP && rcnt_q == 3'd0) begin
                                    state_q <= after_q;
                                    if (after_q == S_RDTOK) tx_q <= 8'hFE;
                                end else begin
                                    if (state_q == S_RESP) rcnt_q <= rcnt_q - 3'd1;
                                    state_q <= S_RESP;
                                    tx_q    <= resp_q[39:32];
                                    resp_q  <= {resp_q[31:0], 8'hFF};
                                end
                            end
                            S_RDTOK: begin
                                state_q    <= S_RDDATA;
                                tx_q       <= mem_rdata;
                                mem_addr_q <= {blk_q, 9'd1};
                                cnt_q      <= 9'd0;
                            end
                            S_RDDATA: begin
                                if (cnt_q == 9'd511) begin
                                    state_q <= S_RDCRC;
                                    cnt_q   <= 9'd0;
                                end else begin
                                    tx_q  <= mem_rdata;
                                    cnt_q <= cnt_q + 9'd1;
                                    // Prefetch the byte after the one just loaded, never past the block end.
                                    if (cnt_q < 9'd510) mem_addr_q <= {blk_q, cnt_q + 9'd2};
                                end
                            end
                            S_RDCRC: begin
                                cnt_q <= (cnt_q == 9'd1) ? 9'd0 : cnt_q + 9'd1;
                                if (cnt_q == 9'd1) state_q <= S_CMD;
                            end
                            S_WRTOK: begin
                                if (rx_byte == 8'hFE) begin
                                    state_q <= S_WRDATA;
                                    cnt_q   <= 9'd0;
                                end else if (rx_byte != 8'hFF) begin
                                    state_q <= S_CMD;
                                end
                            end
                            S_WRDATA: begin
                                mem_we_q    <= 1'b1;
                                mem_wdata_q <= rx_byte;
                                mem_addr_q  <= {blk_q, cnt_q};
                                cnt_q       <= (cnt_q == 9'd511) ? 9'd0 : cnt_q + 9'd1;
                                if (cnt_q == 9'd511) state_q <= S_WRCRC;
                            end
                            S_WRCRC: begin
                                cnt_q <= (cnt_q == 9'd1) ? 9'd0 : cnt_q + 9'd1;
                                if (cnt_q == 9'd1) begin
                                    state_q <= S_WRRESP;
                                    tx_q    <= 8'h05;
                                end
                            end
                            S_WRRESP: begin
                                cnt_q <= 9'd0;
                                if (BUSY_BYTES == 0) begin
                                    state_q <= S_CMD;
                                end else begin
                                    state_q <= S_BUSY;
                                    tx_q    <= 8'h00;
                                end
                            end
                            S_BUSY: begin
                                if (cnt_q == BLAST) begin
                                    state_q <= S_CMD;
                                    cnt_q   <= 9'd0;
                                end else begin
                                    cnt_q <= cnt_q + 9'd1;
                                    tx_q  <= 8'h00;
                                end
                            end
                            default: state_q <= S_CMD;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: init sequence, block write, block read and cs_l abort.
// SPI master bit-bangs mode 0 at clk/8; a behavioural memory answers mem_addr one clk later.
// Every result goes through chk(); the closing line reports comparisons and failures.
`timescale 1ns/1ps
module tb_sd_spi_responder;

    logic        clk = 1'b0;
    logic        rst_l, sck, mosi, cs_l;
    logic        miso, miso_oe, mem_we, card_ready;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata, mem_wdata;
    logic [7:0]  mem [0:65535];

    int          n_chk  = 0;
    int          n_fail = 0;
    int          we_cnt = 0;
    int          we_bad = 0;
    int          wbase  = 0;
    logic [7:0]  wxor   = 8'h00;

    always #5 clk = ~clk;

    sd_spi_responder dut (
        .clk(clk), .rst_l(rst_l), .sck(sck), .mosi(mosi), .cs_l(cs_l),
        .miso(miso), .miso_oe(miso_oe), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .card_ready(card_ready)
    );

    // Synchronous memory model: read data appears one clk after the address.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Write-strobe monitor: each pulse must hit the next address of block 1 with the expected byte.
    always @(negedge clk) begin
        if (mem_we) begin
            if (mem_addr !== 16'h0200 + 16'(we_cnt - wbase) ||
                mem_wdata !== (8'(we_cnt - wbase) ^ wxor))
                we_bad++;
            we_cnt++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            repeat (4) @(negedge clk);
            rx[i] = miso;
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic send_cmd(input logic [47:0] f);
        logic [7:0] d;
        for (int b = 0; b < 6; b++) spi_byte(f[47 - 8*b -: 8], d);
    endtask

    task automatic rd(input string tag, input logic [7:0] exp);
        logic [7:0] r;
        spi_byte(8'hFF, r);
        chk(tag, 32'(r), 32'(exp));
    endtask

    task automatic wr(input logic [7:0] d);
        logic [7:0] r;
        spi_byte(d, r);
    endtask

    initial begin
        logic [7:0] r;
        rst_l = 1'b0; cs_l = 1'b1; sck = 1'b0; mosi = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_miso", 32'(miso), 32'd1);
        chk("rst_miso_oe", 32'(miso_oe), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_card_ready", 32'(card_ready), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        rst_l = 1'b1;
        repeat (6) @(negedge clk);
        cs_l = 1'b0;
        repeat (6) @(negedge clk);
        chk("miso_oe_cs_low", 32'(miso_oe), 32'd1);

        // CMD0 and a read attempted while still idle
        send_cmd(48'h400000000095);
        rd("cmd0_ncr", 8'hFF);
        rd("cmd0_r1", 8'h01);
        send_cmd(48'h5100000200FF);
        rd("cmd17_idle_ncr", 8'hFF);
        rd("cmd17_idle_r1", 8'h05);

        // CMD8 echo
        send_cmd(48'h48000001AA87);
        rd("cmd8_ncr", 8'hFF);
        rd("cmd8_r1", 8'h01);
        rd("cmd8_b1", 8'h00);
        rd("cmd8_b2", 8'h00);
        rd("cmd8_vhs", 8'h01);
        rd("cmd8_pat", 8'hAA);

        // CMD55 + ACMD41 until ready
        for (int k = 0; k < 3; k++) begin
            send_cmd(48'h7700000000FF);
            rd("cmd55_ncr", 8'hFF);
            rd("cmd55_r1", 8'h01);
            send_cmd(48'h6940000000FF);
            rd("acmd41_ncr", 8'hFF);
            rd("acmd41_r1", (k < 2) ? 8'h01 : 8'h00);
        end
        chk("card_ready_init", 32'(card_ready), 32'd1);

        // CMD58 OCR
        send_cmd(48'h7A00000000FF);
        rd("cmd58_ncr", 8'hFF);
        rd("cmd58_r1", 8'h00);
        rd("ocr_b3", 8'h80);
        rd("ocr_b2", 8'hFF);
        rd("ocr_b1", 8'h80);
        rd("ocr_b0", 8'h00);

        // CMD24 full block write: 0..255 twice into block 1
        wbase = we_cnt; wxor = 8'h00;
        send_cmd(48'h5800000200FF);
        rd("cmd24_ncr", 8'hFF);
        rd("cmd24_r1", 8'h00);
        wr(8'hFF);
        wr(8'hFE);
        for (int i = 0; i < 512; i++) wr(8'(i));
        wr(8'hFF);
        wr(8'hFF);
        rd("wr_dresp", 8'h05);
        rd("wr_busy0", 8'h00);
        rd("wr_busy1", 8'h00);
        rd("wr_after", 8'hFF);
        repeat (4) @(negedge clk);
        chk("wr_we_count", we_cnt - wbase, 32'd512);
        chk("wr_we_bad", we_bad, 32'd0);

        // CMD17 full block read-back
        send_cmd(48'h5100000200FF);
        rd("cmd17_ncr", 8'hFF);
        rd("cmd17_r1", 8'h00);
        rd("cmd17_gap", 8'hFF);
        rd("cmd17_token", 8'hFE);
        for (int i = 0; i < 512; i++) begin
            spi_byte(8'hFF, r);
            chk("rd_data", 32'(r), 32'(i & 255));
        end
        rd("rd_crc0", 8'hFF);
        rd("rd_crc1", 8'hFF);

        // CMD24 aborted by cs_l after 100 data bytes
        wbase = we_cnt; wxor = 8'h5A;
        send_cmd(48'h5800000200FF);
        rd("abt_ncr", 8'hFF);
        rd("abt_r1", 8'h00);
        wr(8'hFE);
        for (int i = 0; i < 100; i++) wr(8'(i) ^ 8'h5A);
        cs_l = 1'b1;
        repeat (8) @(negedge clk);
        chk("abt_miso_oe", 32'(miso_oe), 32'd0);
        chk("abt_miso", 32'(miso), 32'd1);
        spi_byte(8'h12, r);
        chk("abt_miso_byte", 32'(r), 32'hFF);
        spi_byte(8'h34, r);
        repeat (4) @(negedge clk);
        chk("abt_we_count", we_cnt - wbase, 32'd100);
        chk("abt_we_bad", we_bad, 32'd0);
        chk("abt_card_ready", 32'(card_ready), 32'd1);
        cs_l = 1'b0;
        repeat (8) @(negedge clk);

        // Read after abort is answered normally; first bytes come from the partial write
        send_cmd(48'h5100000200FF);
        rd("abt_rd_ncr", 8'hFF);
        rd("abt_rd_r1", 8'h00);
        rd("abt_rd_gap", 8'hFF);
        rd("abt_rd_token", 8'hFE);
        for (int i = 0; i < 4; i++) begin
            spi_byte(8'hFF, r);
            chk("abt_rd_data", 32'(r), 32'(8'(i) ^ 8'h5A));
        end
        cs_l = 1'b1;
        repeat (8) @(negedge clk);
        cs_l = 1'b0;
        repeat (8) @(negedge clk);

        // CMD0 again returns the card to idle
        send_cmd(48'h400000000095);
        rd("cmd0b_ncr", 8'hFF);
        rd("cmd0b_r1", 8'h01);
        repeat (4) @(negedge clk);
        chk("cmd0b_card_ready", 32'(card_ready), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
